// File: rtl/prog_loader.sv
// Boot-time instruction-memory writer: assembles little-endian words from a
// length-prefixed byte stream and holds the core until the image is complete.
module prog_loader #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        core_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
   } state_t;

   localparam logic [31:0]     MAX_N    = 32'd1 << ADDR_W;
   localparam logic [ADDR_W:0] WIDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state_q, state_d;
   logic [15:0]     n_q, n_d;
   logic [ADDR_W:0] widx_q, widx_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [31:0]     wbuf_q, wbuf_d;
   logic [15:0]     n_full;
   logic            xfer;

   assign xfer   = in_valid && in_ready;
   assign n_full = {in_data, n_q[7:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         widx_q  <= '0;
         bcnt_q  <= '0;
         wbuf_q  <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         widx_q  <= widx_d;
         bcnt_q  <= bcnt_d;
         wbuf_q  <= wbuf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      widx_d  = widx_q;
      bcnt_d  = bcnt_q;
      wbuf_d  = wbuf_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d = S_LEN_LO;
               widx_d  = '0;
               bcnt_d  = '0;
            end
         end
         S_LEN_LO: begin
            if (xfer) begin
               n_d[7:0] = in_data;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               n_d[15:8] = in_data;
               if (n_full == 16'd0) begin
                  state_d = S_DONE;
               end else if (32'(n_full) > MAX_N) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_DATA;
                  widx_d  = '0;
                  bcnt_d  = '0;
               end
            end
         end
         S_DATA: begin
            // right shift leaves the first byte of the word in [7:0]
            if (xfer) begin
               wbuf_d = {in_data, wbuf_q[31:8]};
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            widx_d = widx_q + WIDX_ONE;
            if (32'(widx_q) + 32'd1 == 32'(n_q)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_DATA;
               bcnt_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_ready  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
   assign mem_we    = (state_q == S_WRITE);
   assign mem_addr  = BASE_ADDR + 64'({widx_q, 2'b00});
   assign mem_wdata = wbuf_q;
   assign busy      = in_ready || mem_we;
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign core_hold = (state_q != S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: per-cycle vector table plus multi-cycle load sequences.
module tb_prog_loader;

   localparam logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FFF8;
   // expected {in_ready, mem_we, busy, done, err, core_hold}
   localparam logic [5:0] LL = 6'b101001;
   localparam logic [5:0] WR = 6'b011001;
   localparam logic [5:0] DN = 6'b000100;
   localparam logic [5:0] ER = 6'b000011;
   localparam logic [5:0] RS = 6'b000001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready, mem_we, core_hold, busy, done, err;
   logic [63:0] mem_addr;
   logic [31:0] mem_wdata;

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [63:0] log_a [$];
   logic [31:0] log_d [$];
   logic [31:0] tw [4];

   typedef struct {
      logic        s;
      logic        v;
      logic [7:0]  d;
      logic [5:0]  exp;
      logic [63:0] addr;
      logic [31:0] wdata;
   } vec_t;
   vec_t tbl [19];

   prog_loader #(.ADDR_W(2), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_hold(core_hold),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         log_a.push_back(mem_addr);
         log_d.push_back(mem_wdata);
      end
   end

   function automatic logic [5:0] outv();
      return {in_ready, mem_we, busy, done, err, core_hold};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int unsigned gap);
      int unsigned k;
      k = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && k < 20) begin
         step();
         k++;
      end
      if (!in_ready) chk("ready_timeout", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      in_data  = 8'h5A;
      repeat (gap) step();
   endtask

   task automatic send_words(input int unsigned first, input int unsigned n, input int unsigned gap);
      for (int unsigned i = first; i < first + n; i++)
         for (int unsigned j = 0; j < 4; j++)
            send_byte(tw[i][8*j +: 8], gap);
   endtask

   task automatic wait_end();
      int unsigned k;
      k = 0;
      while (!done && !err && k < 50) begin
         step();
         k++;
      end
      chk("load_end", 64'({done, err, core_hold}), 64'(3'b100));
   endtask

   task automatic check_log(input int unsigned n);
      chk("wr_count", 64'(log_a.size()), 64'(n));
      for (int unsigned i = 0; i < n && i < log_a.size(); i++) begin
         chk("wr_addr", log_a[i], BASE + 64'(4 * i));
         chk("wr_data", 64'(log_d[i]), 64'(tw[i]));
      end
   endtask

   task automatic load(input int unsigned n, input int unsigned gap);
      log_a.delete();
      log_d.delete();
      pulse_start();
      send_byte(n[7:0], gap);
      send_byte(n[15:8], gap);
      send_words(0, n, gap);
      wait_end();
      check_log(n);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 8'h00, LL, 64'h0, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 8'h01, LL, 64'h0, 32'h0};
      tbl[2]  = '{1'b0, 1'b1, 8'h00, LL, 64'h0, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 8'h13, LL, 64'h0, 32'h0};
      tbl[4]  = '{1'b0, 1'b1, 8'h05, LL, 64'h0, 32'h0};
      tbl[5]  = '{1'b0, 1'b1, 8'hA0, LL, 64'h0, 32'h0};
      tbl[6]  = '{1'b0, 1'b1, 8'h00, WR, BASE, 32'h00A00513};
      tbl[7]  = '{1'b0, 1'b0, 8'h00, DN, 64'h0, 32'h0};
      tbl[8]  = '{1'b0, 1'b1, 8'hAA, DN, 64'h0, 32'h0};
      tbl[9]  = '{1'b1, 1'b0, 8'h00, LL, 64'h0, 32'h0};
      tbl[10] = '{1'b0, 1'b1, 8'h00, LL, 64'h0, 32'h0};
      tbl[11] = '{1'b0, 1'b1, 8'h00, DN, 64'h0, 32'h0};
      tbl[12] = '{1'b1, 1'b0, 8'h00, LL, 64'h0, 32'h0};
      tbl[13] = '{1'b0, 1'b1, 8'h05, LL, 64'h0, 32'h0};
      tbl[14] = '{1'b0, 1'b1, 8'h00, ER, 64'h0, 32'h0};
      tbl[15] = '{1'b0, 1'b1, 8'h11, ER, 64'h0, 32'h0};
      tbl[16] = '{1'b1, 1'b0, 8'h00, LL, 64'h0, 32'h0};
      tbl[17] = '{1'b0, 1'b1, 8'h00, LL, 64'h0, 32'h0};
      tbl[18] = '{1'b0, 1'b1, 8'h01, ER, 64'h0, 32'h0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", 64'(outv()), 64'(RS));
      chk("reset_addr", mem_addr, BASE);
      chk("reset_wdata", 64'(mem_wdata), 64'h0);
      rst_n = 1'b1;
      step();

      for (int unsigned i = 0; i < 19; i++) begin
         start    = tbl[i].s;
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         step();
         start    = 1'b0;
         in_valid = 1'b0;
         chk($sformatf("vec%0d", i), 64'(outv()), 64'(tbl[i].exp));
         if (tbl[i].exp[4]) begin
            chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(tbl[i].wdata));
         end
      end
      chk("table_wr_count", 64'(log_a.size()), 64'd1);

      // full-depth load straight out of ERR; addresses wrap past 2^64
      tw[0] = 32'h11223344; tw[1] = 32'h55667788;
      tw[2] = 32'h99AABBCC; tw[3] = 32'hDDEEFF00;
      load(4, 0);

      tw[0] = 32'h00000093; tw[1] = 32'hFFF00113; tw[2] = 32'h80000037;
      load(3, 1);

      // start while in DATA must be ignored
      log_a.delete();
      log_d.delete();
      tw[0] = 32'hCAFEF00D; tw[1] = 32'h12345678;
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(tw[0][7:0], 0);
      send_byte(tw[0][15:8], 0);
      pulse_start();
      chk("start_in_data", 64'(outv()), 64'(LL));
      send_byte(tw[0][23:16], 0);
      send_byte(tw[0][31:24], 0);
      send_words(1, 1, 0);
      wait_end();
      check_log(2);

      // reset mid-load after six data bytes
      log_a.delete();
      log_d.delete();
      tw[0] = 32'hDEADBEEF; tw[1] = 32'h0BADF00D;
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_words(0, 1, 0);
      send_byte(tw[1][7:0], 0);
      send_byte(tw[1][15:8], 0);
      rst_n = 1'b0;
      #2;
      chk("midrst_outs", 64'(outv()), 64'(RS));
      chk("midrst_addr", mem_addr, BASE);
      chk("midrst_wdata", 64'(mem_wdata), 64'h0);
      check_log(1);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      tw[0] = 32'h00100073; tw[1] = 32'h00008067;
      load(2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
